// File: rtl/apb_master_exe_seq_w47.sv
// APB master sequencer: writes OPER/ARGA/ARGB to addresses 0..2, idles EXE_WAIT cycles, then reads result (addr 0) and status (addr 1).
// All outputs registered; slave stalls via PREADY, bounded by TIMEOUT; PSLVERR or timeout aborts to DONE.
`timescale 1ns/1ps
module apb_master_exe_seq_w47 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int EXE_WAIT   = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                  i_PCLK,
   input  logic                  i_PRESET,
   input  logic                  i_START,
   input  logic [DATA_WIDTH-1:0] i_OPER,
   input  logic [DATA_WIDTH-1:0] i_ARGA,
   input  logic [DATA_WIDTH-1:0] i_ARGB,
   output logic                  o_BUSY,
   output logic                  o_DONE,
   output logic [DATA_WIDTH-1:0] o_RESULT,
   output logic [3:0]            o_STATUS,
   output logic [1:0]            o_ERR,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PSEL,
   output logic                  o_PENABLE,
   output logic                  o_PWRITE,
   output logic [DATA_WIDTH-1:0] o_PWDATA,
   input  logic                  i_PREADY,
   input  logic [DATA_WIDTH-1:0] i_PRDATA,
   input  logic                  i_PSLVERR
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int WW = (EXE_WAIT > 1) ? $clog2(EXE_WAIT) : 1;
   localparam int XW = ADDR_WIDTH + 1 + DATA_WIDTH;
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'((EXE_WAIT > 0) ? EXE_WAIT - 1 : 0);

   logic [2:0]            r_state;
   logic [2:0]            r_idx;
   logic [TW-1:0]         r_tmo;
   logic [WW-1:0]         r_wcnt;
   logic [DATA_WIDTH-1:0] r_oper, r_arga, r_argb;
   logic                  r_busy, r_done, r_psel, r_penable, r_pwrite;
   logic [DATA_WIDTH-1:0] r_result, r_pwdata;
   logic [3:0]            r_status;
   logic [1:0]            r_err;
   logic [ADDR_WIDTH-1:0] r_paddr;

   logic                  w_to_setup, w_to_access, w_to_wait, w_to_done, w_to_idle;
   logic                  w_capture, w_tmo_inc, w_wait_inc;
   logic [2:0]            w_nidx;
   logic [1:0]            w_abort_err;
   logic [DATA_WIDTH-1:0] w_op, w_a, w_b;
   logic [XW-1:0]         w_xfer;

   // {address, direction, write data} presented in SETUP for a given transfer index
   function automatic logic [XW-1:0] f_xfer(input logic [2:0] idx,
                                            input logic [DATA_WIDTH-1:0] op,
                                            input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b);
      logic [ADDR_WIDTH-1:0] addr;
      logic                  wr;
      logic [DATA_WIDTH-1:0] wd;
      addr = '0;
      wr   = 1'b0;
      wd   = '0;
      case (idx)
         3'd0: begin wr = 1'b1; wd = op; end
         3'd1: begin addr = ADDR_WIDTH'(1); wr = 1'b1; wd = a; end
         3'd2: begin addr = ADDR_WIDTH'(2); wr = 1'b1; wd = b; end
         3'd4: addr = ADDR_WIDTH'(1);
         default: ;
      endcase
      return {addr, wr, wd};
   endfunction

   always_comb begin
      w_to_setup  = 1'b0;
      w_to_access = 1'b0;
      w_to_wait   = 1'b0;
      w_to_done   = 1'b0;
      w_to_idle   = 1'b0;
      w_capture   = 1'b0;
      w_tmo_inc   = 1'b0;
      w_wait_inc  = 1'b0;
      w_nidx      = r_idx;
      w_abort_err = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (i_START) begin
               w_to_setup = 1'b1;
               w_nidx     = 3'd0;
            end
         end
         S_SETUP: w_to_access = 1'b1;
         S_ACCESS: begin
            if (i_PREADY) begin
               if (i_PSLVERR) begin
                  w_to_done   = 1'b1;
                  w_abort_err = 2'b01;
               end else begin
                  w_capture = 1'b1;
                  case (r_idx)
                     3'd2: begin
                        if (EXE_WAIT == 0) begin
                           w_to_setup = 1'b1;
                           w_nidx     = 3'd3;
                        end else begin
                           w_to_wait = 1'b1;
                        end
                     end
                     3'd4:    w_to_done = 1'b1;
                     default: begin
                        w_to_setup = 1'b1;
                        w_nidx     = r_idx + 3'd1;
                     end
                  endcase
               end
            end else if (r_tmo == TMO_LAST) begin
               w_to_done   = 1'b1;
               w_abort_err = 2'b10;
            end else begin
               w_tmo_inc = 1'b1;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WAIT_LAST) begin
               w_to_setup = 1'b1;
               w_nidx     = 3'd3;
            end else begin
               w_wait_inc = 1'b1;
            end
         end
         S_DONE:  w_to_idle = 1'b1;
         default: w_to_idle = 1'b1;
      endcase
      // operands are captured on the accepting edge, so index 0 must use the live inputs
      w_op   = (r_state == S_IDLE) ? i_OPER : r_oper;
      w_a    = (r_state == S_IDLE) ? i_ARGA : r_arga;
      w_b    = (r_state == S_IDLE) ? i_ARGB : r_argb;
      w_xfer = f_xfer(w_nidx, w_op, w_a, w_b);
   end

   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         r_state   <= S_IDLE;
         r_idx     <= 3'd0;
         r_tmo     <= '0;
         r_wcnt    <= '0;
         r_oper    <= '0;
         r_arga    <= '0;
         r_argb    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_status  <= 4'd0;
         r_err     <= 2'b00;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
      end else begin
         r_done <= w_to_done;
         if (r_state == S_IDLE && i_START) begin
            r_oper   <= i_OPER;
            r_arga   <= i_ARGA;
            r_argb   <= i_ARGB;
            r_result <= '0;
            r_status <= 4'd0;
            r_err    <= 2'b00;
            r_busy   <= 1'b1;
         end
         if (w_to_setup) begin
            r_state   <= S_SETUP;
            r_idx     <= w_nidx;
            r_tmo     <= '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            {r_paddr, r_pwrite, r_pwdata} <= w_xfer;
         end
         if (w_to_access) begin
            r_state   <= S_ACCESS;
            r_penable <= 1'b1;
         end
         if (w_to_wait || w_to_done) begin
            r_state   <= w_to_wait ? S_WAIT : S_DONE;
            r_wcnt    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
         end
         if (w_abort_err != 2'b00) r_err <= w_abort_err;
         if (w_tmo_inc)  r_tmo  <= r_tmo + 1'b1;
         if (w_wait_inc) r_wcnt <= r_wcnt + 1'b1;
         if (w_capture && r_idx == 3'd3) r_result <= i_PRDATA;
         if (w_capture && r_idx == 3'd4) r_status <= i_PRDATA[3:0];
         if (w_to_idle) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end
      end
   end

   assign o_BUSY    = r_busy;
   assign o_DONE    = r_done;
   assign o_RESULT  = r_result;
   assign o_STATUS  = r_status;
   assign o_ERR     = r_err;
   assign o_PADDR   = r_paddr;
   assign o_PSEL    = r_psel;
   assign o_PENABLE = r_penable;
   assign o_PWRITE  = r_pwrite;
   assign o_PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_master_exe_seq_w47.sv
// Directed bench: instance A (EXE_WAIT=2) against a one-wait-state slave model, instance B (EXE_WAIT=0) against a zero-wait slave.
`timescale 1ns/1ps
module tb_apb_master_exe_seq_w47;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam int XW = AW + 1 + DW;
   localparam int OW = 1 + 1 + DW + 4 + 2 + AW + 1 + 1 + 1 + DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_start, a_busy, a_done, a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
   logic [DW-1:0] a_oper, a_arga, a_argb, a_result, a_pwdata, a_prdata;
   logic [3:0]    a_status;
   logic [1:0]    a_err;
   logic [AW-1:0] a_paddr;
   logic          b_start, b_busy, b_done, b_psel, b_penable, b_pwrite, b_pready, b_pslverr;
   logic [DW-1:0] b_oper, b_arga, b_argb, b_result, b_pwdata, b_prdata;
   logic [3:0]    b_status;
   logic [1:0]    b_err;
   logic [AW-1:0] b_paddr;
   logic [OW-1:0] a_outs, b_outs;

   assign a_outs = {a_busy, a_done, a_result, a_status, a_err, a_paddr, a_psel, a_penable, a_pwrite, a_pwdata};
   assign b_outs = {b_busy, b_done, b_result, b_status, b_err, b_paddr, b_psel, b_penable, b_pwrite, b_pwdata};

   apb_master_exe_seq_w47 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EXE_WAIT(2), .TIMEOUT(16)) u_dut_a (
      .i_PCLK(clk), .i_PRESET(rst), .i_START(a_start), .i_OPER(a_oper), .i_ARGA(a_arga), .i_ARGB(a_argb),
      .o_BUSY(a_busy), .o_DONE(a_done), .o_RESULT(a_result), .o_STATUS(a_status), .o_ERR(a_err),
      .o_PADDR(a_paddr), .o_PSEL(a_psel), .o_PENABLE(a_penable), .o_PWRITE(a_pwrite), .o_PWDATA(a_pwdata),
      .i_PREADY(a_pready), .i_PRDATA(a_prdata), .i_PSLVERR(a_pslverr));

   apb_master_exe_seq_w47 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EXE_WAIT(0), .TIMEOUT(16)) u_dut_b (
      .i_PCLK(clk), .i_PRESET(rst), .i_START(b_start), .i_OPER(b_oper), .i_ARGA(b_arga), .i_ARGB(b_argb),
      .o_BUSY(b_busy), .o_DONE(b_done), .o_RESULT(b_result), .o_STATUS(b_status), .o_ERR(b_err),
      .o_PADDR(b_paddr), .o_PSEL(b_psel), .o_PENABLE(b_penable), .o_PWRITE(b_pwrite), .o_PWDATA(b_pwdata),
      .i_PREADY(b_pready), .i_PRDATA(b_prdata), .i_PSLVERR(b_pslverr));

   int n_cmp = 0;
   int n_bad = 0;

   // slave A state: one wait state per transfer, optional hang / error on a given transfer number
   int            n_log = 0;
   int            hang_n = -1;
   int            err_n = -1;
   int            acc_cnt = 0;
   int            last_acc = 0;
   int            a_psel_cyc = 0;
   int            a_done_cnt = 0;
   int            a_bus_viol = 0;
   logic [DW-1:0] rd0 = '0;
   logic [DW-1:0] rd1 = '0;
   logic [XW-1:0] log_ent [0:63];
   int            b_psel_cyc = 0;
   int            b_setup_cyc = 0;

   always @(negedge clk) begin
      if (a_psel) a_psel_cyc++;
      if (a_done) a_done_cnt++;
      if (!a_psel && (a_paddr != '0 || a_pwrite || a_pwdata != '0)) a_bus_viol++;
      if (a_psel && a_penable) begin
         acc_cnt++;
         last_acc = acc_cnt;
         if (n_log != hang_n && acc_cnt >= 2) begin
            a_pready  = 1'b1;
            a_prdata  = (a_paddr == '0) ? rd0 : rd1;
            a_pslverr = (n_log == err_n);
            log_ent[n_log] = {a_paddr, a_pwrite, a_pwdata};
            n_log++;
         end else begin
            a_pready  = 1'b0;
            a_pslverr = 1'b0;
         end
      end else begin
         acc_cnt   = 0;
         a_pready  = 1'b0;
         a_pslverr = 1'b0;
      end
      if (b_psel) b_psel_cyc++;
      if (b_psel && !b_penable) b_setup_cyc++;
   end

   // Starts a command on A; m = edges after the accepting edge at which o_DONE is first seen (-1 if never)
   task automatic run_a(input logic [DW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, output int m);
      @(negedge clk);
      a_start = 1'b1; a_oper = op; a_arga = a; a_argb = b;
      @(posedge clk); #1;
      a_start = 1'b0;
      m = -1;
      for (int n = 0; n < 200; n++) begin
         if (a_done) begin m = n; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (a_outs !== '0) begin n_bad++; $display("FAIL reset_outs_a: got %h want 0", a_outs); end
      n_cmp++; if (b_outs !== '0) begin n_bad++; $display("FAIL reset_outs_b: got %h want 0", b_outs); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (a_outs !== '0) begin n_bad++; $display("FAIL idle_outs_a: got %h want 0", a_outs); end
   endtask

   task automatic test_nominal;
      int m, base, psel0, done0, viol0;
      logic [XW-1:0] exp_x [5];
      exp_x[0] = {16'd0, 1'b1, 8'd3};
      exp_x[1] = {16'd1, 1'b1, 8'd5};
      exp_x[2] = {16'd2, 1'b1, 8'd2};
      exp_x[3] = {16'd0, 1'b0, 8'd0};
      exp_x[4] = {16'd1, 1'b0, 8'd0};
      rd0 = 8'h07; rd1 = 8'hFA;
      base = n_log; psel0 = a_psel_cyc; done0 = a_done_cnt; viol0 = a_bus_viol;
      run_a(8'd3, 8'd5, 8'd2, m);
      n_cmp++; if (m + 1 != 18) begin n_bad++; $display("FAIL nominal_done_edge: got k+%0d want k+18", m + 1); end
      n_cmp++; if (a_busy !== 1'b1 || a_psel !== 1'b0) begin n_bad++; $display("FAIL nominal_done_cycle: busy=%b psel=%b want 1 0", a_busy, a_psel); end
      n_cmp++; if (n_log - base != 5) begin n_bad++; $display("FAIL nominal_xfer_count: got %0d want 5", n_log - base); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (log_ent[base + i] !== exp_x[i]) begin
            n_bad++; $display("FAIL nominal_xfer%0d: got %h want %h", i, log_ent[base + i], exp_x[i]);
         end
      end
      n_cmp++; if (a_result !== 8'h07) begin n_bad++; $display("FAIL nominal_result: got %h want 07", a_result); end
      n_cmp++; if (a_status !== 4'hA) begin n_bad++; $display("FAIL nominal_status: got %h want a", a_status); end
      n_cmp++; if (a_err !== 2'b00) begin n_bad++; $display("FAIL nominal_err: got %b want 00", a_err); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (a_done_cnt - done0 != 1) begin n_bad++; $display("FAIL nominal_done_pulses: got %0d want 1", a_done_cnt - done0); end
      n_cmp++; if (a_psel_cyc - psel0 != 15) begin n_bad++; $display("FAIL nominal_psel_cycles: got %0d want 15", a_psel_cyc - psel0); end
      n_cmp++; if (a_bus_viol != viol0) begin n_bad++; $display("FAIL nominal_idle_bus_zero: got %0d want %0d", a_bus_viol, viol0); end
      n_cmp++; if (a_busy !== 1'b0 || a_result !== 8'h07) begin n_bad++; $display("FAIL nominal_hold: busy=%b result=%h want 0 07", a_busy, a_result); end
   endtask

   task automatic test_slverr;
      int m, base, psel0, done0;
      base = n_log; psel0 = a_psel_cyc; done0 = a_done_cnt;
      err_n = n_log + 1;
      run_a(8'h11, 8'h22, 8'h33, m);
      n_cmp++; if (m != 6) begin n_bad++; $display("FAIL slverr_done_edge: got %0d want 6", m); end
      n_cmp++; if (a_err !== 2'b01) begin n_bad++; $display("FAIL slverr_err: got %b want 01", a_err); end
      repeat (6) @(posedge clk);
      #1;
      err_n = -1;
      n_cmp++; if (n_log - base != 2) begin n_bad++; $display("FAIL slverr_xfers: got %0d want 2", n_log - base); end
      n_cmp++; if (a_psel_cyc - psel0 != 6) begin n_bad++; $display("FAIL slverr_psel_cycles: got %0d want 6", a_psel_cyc - psel0); end
      n_cmp++; if (a_done_cnt - done0 != 1) begin n_bad++; $display("FAIL slverr_done_pulses: got %0d want 1", a_done_cnt - done0); end
      n_cmp++; if (a_result !== 8'h00 || a_err !== 2'b01) begin n_bad++; $display("FAIL slverr_hold: result=%h err=%b want 00 01", a_result, a_err); end
   endtask

   task automatic test_timeout;
      int m, base;
      base = n_log;
      hang_n = n_log + 3;
      run_a(8'h01, 8'h02, 8'h03, m);
      n_cmp++; if (m != 28) begin n_bad++; $display("FAIL timeout_done_edge: got %0d want 28", m); end
      n_cmp++; if (a_psel !== 1'b0 || a_penable !== 1'b0) begin n_bad++; $display("FAIL timeout_bus_drop: psel=%b penable=%b want 0 0", a_psel, a_penable); end
      n_cmp++; if (a_err !== 2'b10) begin n_bad++; $display("FAIL timeout_err: got %b want 10", a_err); end
      n_cmp++; if (last_acc != 16) begin n_bad++; $display("FAIL timeout_access_cycles: got %0d want 16", last_acc); end
      n_cmp++; if (n_log - base != 3) begin n_bad++; $display("FAIL timeout_xfers: got %0d want 3", n_log - base); end
      hang_n = -1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_start_ignored;
      int base, psel0, done0;
      logic got_done;
      base = n_log; psel0 = a_psel_cyc; done0 = a_done_cnt; got_done = 1'b0;
      rd0 = 8'h42; rd1 = 8'h05;
      @(negedge clk);
      a_start = 1'b1; a_oper = 8'h04; a_arga = 8'h06; a_argb = 8'h09;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (a_penable) break;
         @(posedge clk); #1;
      end
      a_start = 1'b1; a_oper = 8'hEE; a_arga = 8'hDD; a_argb = 8'hCC;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (a_done) begin got_done = 1'b1; break; end
         @(posedge clk); #1;
      end
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      n_cmp++; if (got_done !== 1'b1) begin n_bad++; $display("FAIL ignore_done_seen: got %b want 1", got_done); end
      n_cmp++; if (a_done_cnt - done0 != 1) begin n_bad++; $display("FAIL ignore_done_pulses: got %0d want 1", a_done_cnt - done0); end
      n_cmp++; if (n_log - base != 5) begin n_bad++; $display("FAIL ignore_xfers: got %0d want 5", n_log - base); end
      n_cmp++; if (a_psel_cyc - psel0 != 15) begin n_bad++; $display("FAIL ignore_psel_cycles: got %0d want 15", a_psel_cyc - psel0); end
      n_cmp++; if (log_ent[base + 1] !== {16'd1, 1'b1, 8'h06}) begin n_bad++; $display("FAIL ignore_arga_write: got %h want 00011_06", log_ent[base + 1]); end
      n_cmp++; if (a_result !== 8'h42 || a_status !== 4'h5) begin n_bad++; $display("FAIL ignore_results: result=%h status=%h want 42 5", a_result, a_status); end
   endtask

   task automatic test_reset_midway;
      int m, base, done0;
      base = n_log; done0 = a_done_cnt;
      rd0 = 8'h99; rd1 = 8'h0C;
      @(negedge clk);
      a_start = 1'b1; a_oper = 8'h55; a_arga = 8'h66; a_argb = 8'h77;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (n_log - base == 3 && a_penable) break;
         @(posedge clk); #1;
      end
      n_cmp++; if (a_penable !== 1'b1 || a_pwrite !== 1'b0) begin n_bad++; $display("FAIL midrst_reach_read: penable=%b pwrite=%b want 1 0", a_penable, a_pwrite); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (a_outs !== '0) begin n_bad++; $display("FAIL midrst_outs_async: got %h want 0", a_outs); end
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (a_done_cnt != done0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resume: done=%0d busy=%b want %0d 0", a_done_cnt, a_busy, done0); end
      base = n_log;
      run_a(8'h09, 8'h01, 8'h07, m);
      n_cmp++; if (m + 1 != 18) begin n_bad++; $display("FAIL midrst_new_done_edge: got k+%0d want k+18", m + 1); end
      n_cmp++; if (log_ent[base] !== {16'd0, 1'b1, 8'h09}) begin n_bad++; $display("FAIL midrst_first_xfer: got %h want 00001_09", log_ent[base]); end
      n_cmp++; if (a_result !== 8'h99 || a_status !== 4'hC || a_err !== 2'b00) begin n_bad++; $display("FAIL midrst_new_results: result=%h status=%h err=%b want 99 c 00", a_result, a_status, a_err); end
   endtask

   task automatic test_back_to_back;
      int m, psel0, setup0;
      psel0 = b_psel_cyc; setup0 = b_setup_cyc;
      @(negedge clk);
      b_start = 1'b1; b_oper = 8'h21; b_arga = 8'h43; b_argb = 8'h65;
      @(posedge clk); #1;
      b_start = 1'b0;
      n_cmp++; if ({b_psel, b_penable, b_pwrite, b_paddr, b_pwdata} !== {1'b1, 1'b0, 1'b1, 16'd0, 8'h21}) begin
         n_bad++; $display("FAIL b2b_first_setup: psel=%b en=%b wr=%b addr=%h wd=%h want 1 0 1 0000 21", b_psel, b_penable, b_pwrite, b_paddr, b_pwdata);
      end
      m = -1;
      for (int n = 0; n < 100; n++) begin
         if (b_done) begin m = n; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (m + 1 != 11) begin n_bad++; $display("FAIL b2b_done_edge: got k+%0d want k+11", m + 1); end
      n_cmp++; if (b_psel_cyc - psel0 != 10) begin n_bad++; $display("FAIL b2b_psel_cycles: got %0d want 10", b_psel_cyc - psel0); end
      n_cmp++; if (b_setup_cyc - setup0 != 5) begin n_bad++; $display("FAIL b2b_setup_cycles: got %0d want 5", b_setup_cyc - setup0); end
      n_cmp++; if (b_result !== 8'h5C || b_status !== 4'hC || b_err !== 2'b00) begin n_bad++; $display("FAIL b2b_results: result=%h status=%h err=%b want 5c c 00", b_result, b_status, b_err); end
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_oper = '0; a_arga = '0; a_argb = '0;
      a_pready = 1'b0; a_prdata = '0; a_pslverr = 1'b0;
      b_start = 1'b0; b_oper = '0; b_arga = '0; b_argb = '0;
      b_pready = 1'b1; b_prdata = 8'h5C; b_pslverr = 1'b0;
      test_reset();
      test_nominal();
      test_slverr();
      test_timeout();
      test_start_ignored();
      test_reset_midway();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
